// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state, word type, arbiter FSM state
// and the latched RAM request payload.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } arb_state_t;

    typedef struct packed {
        word_t addr;
        word_t data;
        logic  ren;
        logic  wen;
    } ram_req_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Request/response bundle between the datapath, the memory arbiter and the RAM port.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;

    // Arbiter side: serves CPU requests and drives the RAM port.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    // Environment side: CPU requesters plus the RAM model.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/arb_timeout.sv
// Access watchdog: counts cycles a granted RAM access has waited and flags expiry.
module arb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    input  logic done,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Saturates at TIMEOUT so expiry holds until the access is retired.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !done && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data accesses.
// Optional ARB_RR_EN: alternate grants when both requesters contend (default: data priority).
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             nRST,
    memory_arbiter_if.slave  bus
);

    arb_state_t state;
    ram_req_t   req;
    logic       err_q;

    logic dreq;
    logic pick_d;
    logic active;
    logic ram_term;
    logic expired;
    logic done;
    logic fault;

    assign dreq     = bus.dREN | bus.dWEN;
    assign active   = (state != IDLE);
    assign ram_term = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
    assign done     = active && (ram_term || expired);
    // A late ACCESS on the expiry cycle still counts as a clean completion.
    assign fault    = active && ((bus.ramstate == ERROR) ||
                                 (expired && (bus.ramstate != ACCESS)));

`ifdef ARB_RR_EN
    logic last_d;

    // Remembers who was granted last so contention alternates.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            last_d <= 1'b0;
        end else if (state == IDLE) begin
            if (pick_d) begin
                last_d <= 1'b1;
            end else if (bus.iREN) begin
                last_d <= 1'b0;
            end
        end
    end

    assign pick_d = dreq && !(bus.iREN && last_d);
`else
    assign pick_d = dreq;
`endif

    arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (state == IDLE),
        .enable  (active),
        .done    (ram_term),
        .expired (expired)
    );

    // Grant FSM; RAM port is driven only from the latched request.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            req   <= '0;
            err_q <= 1'b0;
        end else begin
            if (fault) begin
                err_q <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        state <= DACC;
                        req   <= '{addr: bus.daddr, data: bus.dstore,
                                   ren: ~bus.dWEN, wen: bus.dWEN};
                    end else if (bus.iREN) begin
                        state <= IACC;
                        req   <= '{addr: bus.iaddr, data: '0,
                                   ren: 1'b1, wen: 1'b0};
                    end
                end
                DACC, IACC: begin
                    if (done) begin
                        state   <= IDLE;
                        req.ren <= 1'b0;
                        req.wen <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ramREN   = req.ren;
    assign bus.ramWEN   = req.wen;
    assign bus.ramaddr  = req.addr;
    assign bus.ramstore = req.data;
    assign bus.err      = err_q;

    // Wait lines track their request and drop only in the granted completion cycle.
    assign bus.iwait = bus.iREN && !((state == IACC) && done);
    assign bus.dwait = dreq     && !((state == DACC) && done);
    assign bus.iload = ((state == IACC) && done) ? bus.ramload : '0;
    assign bus.dload = ((state == DACC) && done) ? bus.ramload : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (TIMEOUT=4); RR expectations under ARB_RR_EN.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    memory_arbiter_if bus ();

    memory_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr [4];

        nRST         = 1'b0;
        bus.iREN     = 1'b1;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;

        // Reset values
        #3;
        check("rst_iwait",    32'(bus.iwait),  32'd1);
        check("rst_dwait",    32'(bus.dwait),  32'd0);
        check("rst_ramREN",   32'(bus.ramREN), 32'd0);
        check("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
        check("rst_ramaddr",  bus.ramaddr,     32'd0);
        check("rst_ramstore", bus.ramstore,    32'd0);
        check("rst_err",      32'(bus.err),    32'd0);
        check("rst_iload",    bus.iload,       32'd0);
        bus.iREN = 1'b0;
        #9;
        nRST = 1'b1;

        // Fetch, ACCESS on cycle 2
        next_cycle();
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
        settle();
        check("t1_c0_iwait",  32'(bus.iwait),  32'd1);
        check("t1_c0_ramREN", 32'(bus.ramREN), 32'd0);
        next_cycle(); settle();
        check("t1_c1_ramREN",  32'(bus.ramREN), 32'd1);
        check("t1_c1_ramaddr", bus.ramaddr,     32'h40);
        check("t1_c1_iwait",   32'(bus.iwait),  32'd1);
        check("t1_c1_iload",   bus.iload,       32'd0);
        next_cycle();
        bus.ramstate = ACCESS; bus.ramload = 32'h8C010004;
        settle();
        check("t1_c2_ramREN",  32'(bus.ramREN), 32'd1);
        check("t1_c2_ramaddr", bus.ramaddr,     32'h40);
        check("t1_c2_iwait",   32'(bus.iwait),  32'd0);
        check("t1_c2_iload",   bus.iload,       32'h8C010004);
        check("t1_c2_dload",   bus.dload,       32'd0);
        next_cycle();
        bus.iREN = 1'b0; bus.ramstate = FREE; bus.ramload = '0;
        settle();
        check("t1_c3_ramREN", 32'(bus.ramREN), 32'd0);
        check("t1_c3_iwait",  32'(bus.iwait),  32'd0);
        check("t1_c3_iload",  bus.iload,       32'd0);
        check("t1_c3_err",    32'(bus.err),    32'd0);

        // Store and fetch together: data first, then fetch
        next_cycle();
        bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        bus.iREN = 1'b1; bus.iaddr = 32'h44;  bus.ramstate = BUSY;
        settle();
        check("t2_c0_dwait", 32'(bus.dwait), 32'd1);
        check("t2_c0_iwait", 32'(bus.iwait), 32'd1);
        next_cycle();
        bus.ramstate = ACCESS; bus.ramload = 32'h00001234;
        settle();
        check("t2_c1_ramWEN",   32'(bus.ramWEN), 32'd1);
        check("t2_c1_ramREN",   32'(bus.ramREN), 32'd0);
        check("t2_c1_ramaddr",  bus.ramaddr,     32'h100);
        check("t2_c1_ramstore", bus.ramstore,    32'hDEADBEEF);
        check("t2_c1_dwait",    32'(bus.dwait),  32'd0);
        check("t2_c1_iwait",    32'(bus.iwait),  32'd1);
        check("t2_c1_dload",    bus.dload,       32'h00001234);
        next_cycle();
        bus.dWEN = 1'b0; bus.ramstate = BUSY;
        settle();
        check("t2_c2_ramWEN", 32'(bus.ramWEN), 32'd0);
        check("t2_c2_iwait",  32'(bus.iwait),  32'd1);
        check("t2_c2_dwait",  32'(bus.dwait),  32'd0);
        next_cycle();
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
        settle();
        check("t2_c3_ramREN",   32'(bus.ramREN), 32'd1);
        check("t2_c3_ramWEN",   32'(bus.ramWEN), 32'd0);
        check("t2_c3_ramaddr",  bus.ramaddr,     32'h44);
        check("t2_c3_ramstore", bus.ramstore,    32'd0);
        check("t2_c3_iwait",    32'(bus.iwait),  32'd0);
        check("t2_c3_iload",    bus.iload,       32'hCAFEF00D);
        next_cycle();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        settle();
        check("t2_c4_ramREN", 32'(bus.ramREN), 32'd0);

        // Both requests held continuously
`ifdef ARB_RR_EN
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h300;
        exp_addr[2] = 32'h200; exp_addr[3] = 32'h300;
`else
        exp_addr[0] = 32'h200; exp_addr[1] = 32'h200;
        exp_addr[2] = 32'h200; exp_addr[3] = 32'h200;
`endif
        next_cycle();
        bus.dREN = 1'b1; bus.daddr = 32'h200;
        bus.iREN = 1'b1; bus.iaddr = 32'h300;
        bus.ramstate = ACCESS; bus.ramload = 32'h11111111;
        settle();
        check("t3_idle_ramREN", 32'(bus.ramREN), 32'd0);
        for (int g = 0; g < 4; g++) begin
            next_cycle(); settle();
            check($sformatf("t3_g%0d_ramREN", g),  32'(bus.ramREN), 32'd1);
            check($sformatf("t3_g%0d_ramaddr", g), bus.ramaddr,     exp_addr[g]);
            check($sformatf("t3_g%0d_dwait", g),   32'(bus.dwait),
                  (exp_addr[g] == 32'h200) ? 32'd0 : 32'd1);
            check($sformatf("t3_g%0d_iwait", g),   32'(bus.iwait),
                  (exp_addr[g] == 32'h300) ? 32'd0 : 32'd1);
            next_cycle(); settle();
            check($sformatf("t3_g%0d_gap_ramREN", g), 32'(bus.ramREN), 32'd0);
        end
        bus.dREN = 1'b0; bus.iREN = 1'b0; bus.ramstate = FREE;

        // Stuck RAM: timeout after 4 waiting cycles
        next_cycle();
        bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = BUSY; bus.ramload = 32'h55;
        settle();
        check("t4_c0_dwait", 32'(bus.dwait), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle(); settle();
            check($sformatf("t4_c%0d_dwait", c),  32'(bus.dwait),  32'd1);
            check($sformatf("t4_c%0d_ramREN", c), 32'(bus.ramREN), 32'd1);
            check($sformatf("t4_c%0d_err", c),    32'(bus.err),    32'd0);
        end
        next_cycle(); settle();
        check("t4_c5_dwait", 32'(bus.dwait), 32'd0);
        check("t4_c5_dload", bus.dload,      32'h55);
        next_cycle();
        bus.dREN = 1'b0; bus.ramstate = FREE;
        settle();
        check("t4_c6_err",    32'(bus.err),    32'd1);
        check("t4_c6_ramREN", 32'(bus.ramREN), 32'd0);
        check("t4_c6_dwait",  32'(bus.dwait),  32'd0);
        next_cycle(); next_cycle(); settle();
        check("t4_err_sticky", 32'(bus.err), 32'd1);

        // Reset asserted mid-store
        next_cycle();
        bus.dWEN = 1'b1; bus.daddr = 32'h600; bus.dstore = 32'h12345678; bus.ramstate = BUSY;
        next_cycle(); settle();
        check("t6_pre_ramWEN", 32'(bus.ramWEN), 32'd1);
        check("t6_pre_err",    32'(bus.err),    32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("t6_rst_ramWEN",   32'(bus.ramWEN), 32'd0);
        check("t6_rst_ramREN",   32'(bus.ramREN), 32'd0);
        check("t6_rst_ramaddr",  bus.ramaddr,     32'd0);
        check("t6_rst_ramstore", bus.ramstore,    32'd0);
        check("t6_rst_err",      32'(bus.err),    32'd0);
        check("t6_rst_dwait",    32'(bus.dwait),  32'd1);
        bus.dWEN = 1'b0;
        #3;
        nRST = 1'b1;

        // RAM ERROR during a fetch
        next_cycle();
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.ramstate = BUSY;
        settle();
        check("t5_c0_ramREN", 32'(bus.ramREN), 32'd0);
        check("t5_c0_iwait",  32'(bus.iwait),  32'd1);
        next_cycle(); settle();
        check("t5_c1_ramREN",  32'(bus.ramREN), 32'd1);
        check("t5_c1_ramaddr", bus.ramaddr,     32'h80);
        next_cycle();
        bus.ramstate = ERROR; bus.ramload = 32'hBAD0BAD0;
        settle();
        check("t5_c2_iwait", 32'(bus.iwait), 32'd0);
        check("t5_c2_iload", bus.iload,      32'hBAD0BAD0);
        check("t5_c2_err",   32'(bus.err),   32'd0);
        next_cycle();
        bus.iREN = 1'b0; bus.ramstate = FREE;
        settle();
        check("t5_c3_err",    32'(bus.err),    32'd1);
        check("t5_c3_ramREN", 32'(bus.ramREN), 32'd0);
        check("t5_c3_iwait",  32'(bus.iwait),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port RAM arbiter between the instruction fetch path and the data memory request path. It consumes the registered `dREN`/`dWEN` strobes and the instruction-fetch strobe `iREN`, and grants one requester at a time. It drives the shared RAM port and returns per-requester wait/load signals; the datapath derives `ihit`/`dhit` from these. A timeout guard reports a stuck RAM instead of deadlocking the pipeline.

## Interface

Parameters:
- TIMEOUT, 255: maximum cycles a granted access may wait for `ACCESS` before it is aborted.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction fetch request; held until `iwait` is low.
- iaddr  in  32  fetch address.
- dREN  in  1  data load request; held until `dwait` is low.
- dWEN  in  1  data store request; held until `dwait` is low.
- daddr  in  32  data address.
- dstore  in  32  store data.
- iwait  out  1  low for exactly one cycle when the fetch completes.
- dwait  out  1  low for exactly one cycle when the data access completes.
- iload  out  32  fetch data; valid while `iwait` is low.
- dload  out  32  load data; valid while `dwait` is low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky fault flag; set on RAM ERROR or timeout.

## Operation

- FSM states: IDLE, DACC, IACC.
- IDLE:
  - If `dREN|dWEN`, go to DACC. Otherwise, if `iREN`, go to IACC.
  - On the transition, latch the address, store data and op into registers. If `dREN` and `dWEN` are both high, the access is a write.
- DACC/IACC:
  - RAM outputs are driven only from the latched registers.
  - `ramREN`/`ramWEN` follow the latched op; IACC is always a read.
- Completion:
  - `ramstate==ACCESS`: the granted wait line goes low for that cycle, and `iload`/`dload` = `ramload` combinationally. Next state is IDLE.
  - `ramstate==ERROR`: same completion behaviour (load value = `ramload`), plus `err` is set.
  - Timeout: completes the same way and sets `err`.
- Timeout counter:
  - Cleared on entry to DACC/IACC; increments each cycle without ACCESS/ERROR.
  - On reaching TIMEOUT, the access is aborted as above.
- Dropped requests: if a requester drops its request mid-access, the RAM operation still completes. A completion pulse is emitted, and the requester ignores it.
- Outputs outside a completion cycle:
  - The non-granted wait line is high whenever its request is high. Wait lines are low when no request is pending.
  - `iload`/`dload` = 0.
- `err` clears only on reset.

## Timing

- Reset values: state IDLE; `ramREN`/`ramWEN` = 0; `ramaddr`/`ramstore` = 0; `err` = 0; counter = 0; `iwait`/`dwait` follow their requests (high if requested).
- Minimum latency: request seen in IDLE at cycle 0, RAM enables at cycle 1, earliest completion at cycle 1. Back-to-back accesses to the same requester are therefore 2 cycles apart.
- RAM enables drop in the cycle after completion (state IDLE).
- Reset asserted mid-access: immediate return to reset values; the in-flight op is lost.
- Arbitration is re-evaluated only in IDLE. There is no preemption.

## Configuration

- `ARB_RR_EN` defined: one-bit last-grant register (reset = instruction). If both requests are pending in IDLE and the last grant was data, instruction wins; otherwise data wins.
- `ARB_RR_EN` undefined: data always has priority; the register is absent.

## Structure

- `cpu_types_pkg`: `ramstate_t`, `word_t`, and a new `arb_state_t` enum (IDLE, DACC, IACC).
- Sub-module `arb_timeout`:
  - Ports: clear, enable, done, `expired`.
  - Counter width = `$clog2(TIMEOUT+1)`.

## Test plan

- Reset, then `iREN=1`, `iaddr=0x40`, RAM returns ACCESS on cycle 2 with `ramload=0x8C010004` -> `ramREN=1`, `ramaddr=0x40` on cycles 1-2; `iwait` low only on cycle 2; `iload=0x8C010004`.
- `dWEN=1`, `daddr=0x100`, `dstore=0xDEADBEEF` together with `iREN=1` -> data granted first (`ramWEN=1`, `ramstore=0xDEADBEEF`); after `dwait` pulses low, fetch is served.
- `ARB_RR_EN` defined, `dREN` and `iREN` both held continuously -> grants alternate D, I, D, I.
- `dREN=1`, ramstate held BUSY, TIMEOUT=4 -> `dwait` pulses low on cycle 5; `err=1` and stays 1; state returns to IDLE.
- ramstate=ERROR during IACC -> `iwait` pulses low; `err=1`.
- `nRST` pulsed low mid-DACC -> `ramWEN`/`ramREN` = 0 immediately; state IDLE; `err` = 0.
